vram_fill_scheduler: RTL and testbench
======================================

// Module: vram_fill_scheduler
// PURPOSE
//  Owns the single write port of the 32x32-cell, 3-bit-colour video memory. Merges two requesters:
//  CPU single-cell writes (WVM path) and a hardware rectangle-fill engine started by one command.
//  CPU writes always win; the fill engine stalls for that cycle. Sits between MiniAlu decode and VideoMemory.
// PARAMETERS
//  COLOR_W  3   colour bits per cell
//  COORD_W  5   bits per grid coordinate (grid is 2**COORD_W square)
//  ADDR_W   10  cell address width = 2*COORD_W; address = {Y,X} = Y*32+X
// PORTS
//  Clock          in   1        system clock, all logic on posedge
//  Reset          in   1        synchronous, active-high
//  iCpuWrite      in   1        CPU cell write request, one cycle per write
//  iCpuAddr       in   ADDR_W   CPU target cell address
//  iCpuColor      in   COLOR_W  CPU colour
//  iFillStart     in   1        start rectangle fill (sampled only in IDLE)
//  iFillX0/iFillY0 in  COORD_W  rectangle top-left cell
//  iFillW/iFillH  in   COORD_W+1 width/height in cells, 0..32
//  iFillColor     in   COLOR_W  fill colour
//  oWriteEnable   out  1        to VideoMemory iWriteEnable
//  oWriteAddress  out  ADDR_W   to VideoMemory iWriteAddress
//  oDataOut       out  COLOR_W  to VideoMemory iDataIn
//  oBusy          out  1        high whenever state != IDLE
//  oDone          out  1        one-cycle pulse when fill finishes
// BEHAVIOUR
//  Reset: state=IDLE; oWriteEnable=0, oWriteAddress=0, oDataOut=0, oBusy=0, oDone=0; fill regs cleared.
//  Write port outputs are registered: a write selected in cycle N is visible on the port in N+1.
//  Port select per cycle: iCpuWrite=1 -> CPU addr/colour (any state); else FILL state -> current fill cell;
//   else oWriteEnable=0 (addr/data hold last value).
//  FSM IDLE/FILL/DONE:
//   IDLE: on iFillStart latch X0,Y0,colour; compute XEND=min(X0+W-1,31), YEND=min(Y0+H-1,31) in
//    COORD_W+1-bit arithmetic (no wrap). If W==0 or H==0 -> DONE (no writes), else -> FILL with x=X0,y=Y0.
//   FILL: if iCpuWrite, hold x,y (stall). Else issue write {y,x}; if x==XEND: x<=X0, and if y==YEND -> DONE
//    else y<=y+1; otherwise x<=x+1. Row-major, one cell per non-stalled cycle.
//   DONE: oDone=1 for exactly this cycle, oBusy=1; next state IDLE.
//  Clipping: cells with X0+i>31 or Y0+j>31 are never written; never wraps to column/row 0.
//  iFillStart while FILL/DONE: ignored, no latching. iFillStart and iCpuWrite same cycle in IDLE: both accepted.
//  Fill params are sampled only at start; later input changes do not affect an active fill.
//  Reset mid-fill: next cycle oWriteEnable=0, IDLE, no further fill writes, no oDone pulse.
//  A W x H fill with no stalls occupies FILL for W'*H' cycles (W',H' = clipped sizes).
// TESTING
//  1 Start X0=2,Y0=3,W=2,H=2,colour=5 at cycle N, no CPU -> writes 98,99,130,131 data 5 at N+2..N+5; oDone=1 at N+5 only.
//  2 Same fill, iCpuWrite addr=7 colour=1 at N+2 -> port shows 98,7(data 1),99,130,131 at N+2..N+6; oDone at N+6.
//  3 X0=30,Y0=31,W=4,H=3,colour=2 -> only 1022,1023 written; oDone 1 cycle after last write selected.
//  4 W=0 (any H) -> no oWriteEnable pulses; oBusy=1 for one cycle, oDone=1 at N+1.
//  5 Full-screen fill X0=Y0=0,W=H=32 -> 1024 writes, addresses 0..1023 in order, no gaps; second iFillStart mid-fill ignored.
//  6 Reset asserted mid-fill after 3 writes -> oWriteEnable=0, oBusy=0 next cycle; no oDone; no further writes.

Source files
------------

// File: rtl/vram_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vram_fill_scheduler
// Purpose  : Single write-port owner for the 32x32 x 3-bit video memory.
//            Merges CPU single-cell writes with a rectangle-fill engine.
//            CPU writes always win; the fill engine stalls for that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vram_fill_scheduler #(
  parameter int COLOR_W = 3,
  parameter int COORD_W = 5,
  parameter int ADDR_W  = 2 * COORD_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iCpuWrite,
  input  logic [ADDR_W-1:0]  iCpuAddr,
  input  logic [COLOR_W-1:0] iCpuColor,
  input  logic               iFillStart,
  input  logic [COORD_W-1:0] iFillX0,
  input  logic [COORD_W-1:0] iFillY0,
  input  logic [COORD_W:0]   iFillW,
  input  logic [COORD_W:0]   iFillH,
  input  logic [COLOR_W-1:0] iFillColor,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [COLOR_W-1:0] oDataOut,
  output logic               oBusy,
  output logic               oDone
);

  // Largest legal coordinate, held in the widened (no-wrap) arithmetic width.
  localparam logic [COORD_W:0] c_MAX_COORD = {1'b0, {COORD_W{1'b1}}};
  localparam logic [COORD_W:0] c_ONE       = {{COORD_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_xend;
  logic [COORD_W-1:0] r_yend;
  logic [COLOR_W-1:0] r_color;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_data;
  logic               r_busy;
  logic               r_done;

  logic [COORD_W:0]   w_xend_full;
  logic [COORD_W:0]   w_yend_full;
  logic [COORD_W-1:0] w_xend;
  logic [COORD_W-1:0] w_yend;
  logic               w_empty;

  // Clipped rectangle end coordinates; the extra bit keeps X0+W-1 from wrapping.
  always_comb begin
    w_xend_full = {1'b0, iFillX0} + iFillW - c_ONE;
    w_yend_full = {1'b0, iFillY0} + iFillH - c_ONE;
    w_xend      = (w_xend_full > c_MAX_COORD) ? {COORD_W{1'b1}} : w_xend_full[COORD_W-1:0];
    w_yend      = (w_yend_full > c_MAX_COORD) ? {COORD_W{1'b1}} : w_yend_full[COORD_W-1:0];
    w_empty     = (iFillW == '0) || (iFillH == '0);
  end

  // Fill FSM plus registered write-port arbitration (CPU has priority).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_x0    <= '0;
      r_xend  <= '0;
      r_yend  <= '0;
      r_color <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (iCpuWrite) begin
        r_we   <= 1'b1;
        r_addr <= iCpuAddr;
        r_data <= iCpuColor;
      end
      case (r_state)
        S_IDLE: begin
          if (iFillStart) begin
            r_x0    <= iFillX0;
            r_x     <= iFillX0;
            r_y     <= iFillY0;
            r_xend  <= w_xend;
            r_yend  <= w_yend;
            r_color <= iFillColor;
            r_busy  <= 1'b1;
            if (w_empty) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          // A CPU write this cycle owns the port; the fill position holds.
          if (!iCpuWrite) begin
            r_we   <= 1'b1;
            r_addr <= {r_y, r_x};
            r_data <= r_color;
            if (r_x == r_xend) begin
              r_x <= r_x0;
              if (r_y == r_yend) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oWriteEnable  = r_we;
  assign oWriteAddress = r_addr;
  assign oDataOut      = r_data;
  assign oBusy         = r_busy;
  assign oDone         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vram_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_fill_scheduler
// Purpose  : Scoreboard bench for vram_fill_scheduler. Expected writes and
//            done pulses (with their cycle numbers) are queued when stimulus
//            is driven and retired by a monitor on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_fill_scheduler;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iCpuWrite;
  logic [9:0] iCpuAddr;
  logic [2:0] iCpuColor;
  logic       iFillStart;
  logic [4:0] iFillX0;
  logic [4:0] iFillY0;
  logic [5:0] iFillW;
  logic [5:0] iFillH;
  logic [2:0] iFillColor;
  logic       oWriteEnable;
  logic [9:0] oWriteAddress;
  logic [2:0] oDataOut;
  logic       oBusy;
  logic       oDone;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  vram_fill_scheduler dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iCpuWrite    (iCpuWrite),
    .iCpuAddr     (iCpuAddr),
    .iCpuColor    (iCpuColor),
    .iFillStart   (iFillStart),
    .iFillX0      (iFillX0),
    .iFillY0      (iFillY0),
    .iFillW       (iFillW),
    .iFillH       (iFillH),
    .iFillColor   (iFillColor),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oDataOut     (oDataOut),
    .oBusy        (oBusy),
    .oDone        (oDone)
  );

  always #5 Clock = ~Clock;

  // Cycle number: value seen between two rising edges.
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_wr(input int c, input int a, input int d);
    wr_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  // Drive one start cycle; optionally queue the clipped row-major write list.
  task automatic start_fill(input int x0, input int y0, input int w, input int h,
                            input int col, input bit push);
    int n;
    int k;
    n          = cyc;
    iFillStart = 1'b1;
    iFillX0    = 5'(x0);
    iFillY0    = 5'(y0);
    iFillW     = 6'(w);
    iFillH     = 6'(h);
    iFillColor = 3'(col);
    if (push) begin
      k = 0;
      for (int j = 0; j < h; j++) begin
        for (int i = 0; i < w; i++) begin
          if ((x0 + i) <= 31 && (y0 + j) <= 31) begin
            push_wr(n + 2 + k, (y0 + j) * 32 + (x0 + i), col);
            k++;
          end
        end
      end
      dq.push_back(n + 1 + k);
    end
    tick();
    iFillStart = 1'b0;
    iCpuWrite  = 1'b0;
    // Scramble the parameter inputs: an active fill must not notice.
    iFillX0    = 5'($urandom);
    iFillY0    = 5'($urandom);
    iFillW     = 6'($urandom_range(0, 32));
    iFillH     = 6'($urandom_range(0, 32));
    iFillColor = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (oBusy && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 1, 0);
    repeat (4) tick();
  endtask

  // Monitor: retire queued writes / done pulses and flag anything unexpected or late.
  always @(negedge Clock) begin
    if (oWriteEnable) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", int'(oWriteAddress), -1);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", int'(oWriteAddress), e.addr);
        chk("wr_data", int'(oDataOut), e.data);
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      chk("missed_write_cycle", cyc, wq[0].cyc);
      void'(wq.pop_front());
    end
    if (oDone) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", cyc, -1);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
      end
    end else if (dq.size() > 0 && dq[0] <= cyc) begin
      chk("missed_done_cycle", cyc, dq[0]);
      void'(dq.pop_front());
    end
  end

  initial begin
    int n;
    Reset      = 1'b1;
    iCpuWrite  = 1'b0;
    iCpuAddr   = '0;
    iCpuColor  = '0;
    iFillStart = 1'b0;
    iFillX0    = '0;
    iFillY0    = '0;
    iFillW     = '0;
    iFillH     = '0;
    iFillColor = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();

    // Reset state.
    chk("rst_we", int'(oWriteEnable), 0);
    chk("rst_addr", int'(oWriteAddress), 0);
    chk("rst_data", int'(oDataOut), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oDone), 0);

    // 2x2 fill at (2,3): 98,99,130,131.
    start_fill(2, 3, 2, 2, 5, 1'b1);
    chk("busy_after_start", int'(oBusy), 1);
    wait_idle();

    // Same fill with a CPU write stalling the engine for one cycle.
    n = cyc;
    begin
      push_wr(n + 2, 98, 5);
      push_wr(n + 3, 7, 1);
      push_wr(n + 4, 99, 5);
      push_wr(n + 5, 130, 5);
      push_wr(n + 6, 131, 5);
      dq.push_back(n + 6);
    end
    start_fill(2, 3, 2, 2, 5, 1'b0);
    tick();
    iCpuWrite = 1'b1;
    iCpuAddr  = 10'd7;
    iCpuColor = 3'd1;
    tick();
    iCpuWrite = 1'b0;
    wait_idle();

    // Clipped to the bottom-right corner: only 1022, 1023.
    start_fill(30, 31, 4, 3, 2, 1'b1);
    wait_idle();

    // Zero width: no writes, one busy cycle, done next cycle.
    start_fill(4, 4, 0, 7, 6, 1'b1);
    chk("w0_busy", int'(oBusy), 1);
    tick();
    chk("w0_busy_clear", int'(oBusy), 0);
    wait_idle();

    // Zero height.
    start_fill(4, 4, 9, 0, 6, 1'b1);
    wait_idle();

    // CPU write and fill start in the same idle cycle: both accepted.
    n         = cyc;
    iCpuWrite = 1'b1;
    iCpuAddr  = 10'd555;
    iCpuColor = 3'd4;
    push_wr(n + 1, 555, 4);
    start_fill(31, 0, 3, 2, 3, 1'b1);
    wait_idle();

    // Full screen, with a second start mid-fill that must be ignored.
    start_fill(0, 0, 32, 32, 7, 1'b1);
    repeat (100) tick();
    iFillStart = 1'b1;
    iFillX0    = 5'd5;
    iFillY0    = 5'd5;
    iFillW     = 6'd3;
    iFillH     = 6'd3;
    iFillColor = 3'd1;
    tick();
    iFillStart = 1'b0;
    chk("full_busy_mid", int'(oBusy), 1);
    wait_idle();

    // Reset after three writes: nothing more, no done pulse.
    n = cyc;
    push_wr(n + 2, 0, 3);
    push_wr(n + 3, 1, 3);
    push_wr(n + 4, 2, 3);
    start_fill(0, 0, 8, 8, 3, 1'b0);
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rstmid_we", int'(oWriteEnable), 0);
    chk("rstmid_busy", int'(oBusy), 0);
    chk("rstmid_done", int'(oDone), 0);
    repeat (20) tick();

    chk("writes_outstanding", wq.size(), 0);
    chk("dones_outstanding", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
